// File: rtl/mdu_iterative.sv
// Iterative RV32M MUL/DIV/REM unit: 32-cycle shift-add / restoring divide, special cases and (MDU_FAST_MUL_EN) MUL in one cycle.
// Latency: done_o in T+33 (T+1 for special/fast); holds the front pipeline via stall_o while accepting or iterating, flush aborts.
module mdu_iterative #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [4:0] CTRL_MUL = 5'b01000;
    localparam logic [4:0] CTRL_DIV = 5'b01001;
    localparam logic [4:0] CTRL_REM = 5'b01010;
    localparam int         CW       = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM} op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_in;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_a_q, acc_b_q, acc_r_q, result_q;
    logic            neg_q_q, neg_r_q;

    logic            is_mdu, accept, special, early_done;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic [XLEN-1:0] mul_sum, rem_n, quo_n, quo_fin, rem_fin, fin_res;
    logic [XLEN:0]   r_sh, diff;
    logic            ge;

    always_comb begin
        is_mdu = 1'b1;
        op_in  = OP_MUL;
        case (alu_ctrl)
            CTRL_MUL: op_in = OP_MUL;
            CTRL_DIV: op_in = OP_DIV;
            CTRL_REM: op_in = OP_REM;
            default:  is_mdu = 1'b0;
        endcase
    end

    assign accept = (state_q == S_IDLE) && start_i && is_mdu && !flush_i;
    assign abs_a  = op_a[XLEN-1] ? -op_a : op_a;
    assign abs_b  = op_b[XLEN-1] ? -op_b : op_b;

    // Divide-by-zero and signed overflow are resolved without iterating.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (op_in != OP_MUL) begin
            if (op_b == '0) begin
                special     = 1'b1;
                special_res = (op_in == OP_DIV) ? '1 : op_a;
            end else if (op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1) begin
                special     = 1'b1;
                special_res = (op_in == OP_DIV) ? op_a : '0;
            end
        end
    end

`ifdef MDU_FAST_MUL_EN
    assign early_done = special || (op_in == OP_MUL);
`else
    assign early_done = special;
`endif

    // One iteration step of either datapath; fin_res is the value after the last step.
    assign mul_sum = acc_r_q + (acc_b_q[0] ? acc_a_q : '0);
    assign r_sh    = {acc_r_q, acc_a_q[XLEN-1]};
    assign diff    = r_sh - {1'b0, acc_b_q};
    assign ge      = !diff[XLEN];
    assign rem_n   = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    assign quo_n   = {acc_a_q[XLEN-2:0], ge};
    assign quo_fin = neg_q_q ? -quo_n : quo_n;
    assign rem_fin = neg_r_q ? -rem_n : rem_n;

    always_comb begin
        case (op_q)
            OP_DIV:  fin_res = quo_fin;
            OP_REM:  fin_res = rem_fin;
            default: fin_res = mul_sum;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = early_done ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                if (flush_i)           state_d = S_IDLE;
                else if (cnt_q == '0)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign stall_o  = accept || (state_q == S_BUSY);
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE) && !flush_i;
    assign result_o = result_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            acc_r_q  <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            cnt_q   <= CW'(ITER - 1);
            acc_r_q <= '0;
            neg_q_q <= op_a[XLEN-1] ^ op_b[XLEN-1];
            neg_r_q <= op_a[XLEN-1];
            if (op_in == OP_MUL) begin
                acc_a_q <= op_a;
                acc_b_q <= op_b;
            end else begin
                acc_a_q <= abs_a;
                acc_b_q <= abs_b;
            end
            if (special) result_q <= special_res;
`ifdef MDU_FAST_MUL_EN
            if (op_in == OP_MUL) result_q <= op_a * op_b;
`endif
        end else if (state_q == S_BUSY && !flush_i) begin
            cnt_q <= cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
                acc_r_q <= mul_sum;
                acc_a_q <= acc_a_q << 1;
                acc_b_q <= acc_b_q >> 1;
            end else begin
                acc_r_q <= rem_n;
                acc_a_q <= quo_n;
            end
            if (cnt_q == '0) result_q <= fin_res;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized self-checking bench for mdu_iterative against a plain-arithmetic RV32M model.
module tb_mdu_iterative;

    localparam logic [4:0] MUL = 5'b01000;
    localparam logic [4:0] DIV = 5'b01001;
    localparam logic [4:0] REM = 5'b01010;

    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a, op_b;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_res = '0;

    mdu_iterative #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .alu_ctrl(alu_ctrl),
        .op_a(op_a), .op_b(op_b), .flush_i(flush_i), .stall_o(stall_o),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (c == MUL) return a * b;
        if (b == 32'd0) return (c == DIV) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (c == DIV) ? 32'h8000_0000 : 32'd0;
        if (c == DIV) return sa / sb;
        return sa % sb;
    endfunction

    function automatic int latency(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c != MUL && (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
        if (c == MUL) return 1;
`endif
        return 33;
    endfunction

    // Drives one op from an IDLE cycle, follows it to done_o, and checks timing and result.
    task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        logic [31:0] exp_r;
        int lat, got, stall_err;
        exp_r = model(c, a, b);
        lat = latency(c, a, b);
        got = -1;
        stall_err = 0;
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0;
        start_i = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        #1;
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_stall_T"}, {31'd0, stall_o}, 32'd1);
        check({tag, "_held_result"}, result_o, last_res);
        for (int k = 1; k <= 40 && got < 0; k++) begin
            @(negedge clk);
            if (!hold) start_i = 1'b0;
            #1;
            if (stall_o !== (k < lat)) stall_err++;
            if (done_o === 1'b1) got = k;
        end
        check({tag, "_latency"}, got, lat);
        check({tag, "_result"}, result_o, exp_r);
        check({tag, "_stall_profile"}, stall_err, 0);
        last_res = exp_r;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        alu_ctrl = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_result", result_o, 32'd0);

        run_op("mul_neg", MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op("div_neg", DIV, 32'hFFFF_FFEC, 32'd3, 1'b0);
        run_op("rem_neg", REM, 32'hFFFF_FFEC, 32'd3, 1'b0);
        run_op("rem_negdiv", REM, 32'd20, 32'hFFFF_FFFD, 1'b0);
        run_op("div_zero", DIV, 32'd100, 32'd0, 1'b0);
        run_op("rem_zero", REM, 32'd100, 32'd0, 1'b0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Flush a DIV in its tenth iteration cycle, then accept a MUL right after.
        @(negedge clk);
        start_i = 1'b1; alu_ctrl = DIV; op_a = 32'd1000; op_b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 10) flush_i = 1'b1;
            #1;
            if (k == 10) check("flush_no_done", {31'd0, done_o}, 32'd0);
        end
        run_op("mul_after_flush", MUL, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);

        // Non-MDU codes never start the unit.
        @(negedge clk);
        start_i = 1'b1; alu_ctrl = 5'b00000; op_a = 32'd5; op_b = 32'd6;
        #1;
        check("ign0_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        alu_ctrl = 5'b00111;
        #1;
        check("ign7_stall", {31'd0, stall_o}, 32'd0);
        check("ign0_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("ign7_busy", {31'd0, busy_o}, 32'd0);
        check("ign_done", {31'd0, done_o}, 32'd0);

        // Reset in the middle of a DIV clears everything.
        @(negedge clk);
        start_i = 1'b1; alu_ctrl = DIV; op_a = 32'd99; op_b = 32'd4;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 5) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_done", {31'd0, done_o}, 32'd0);
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        last_res = '0;

        // Back-to-back with start_i held through DONE.
        run_op("b2b_mul", MUL, 32'd3, 32'd5, 1'b1);
        run_op("b2b_div", DIV, 32'd15, 32'd5, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [4:0]  c;
            logic [31:0] a, b;
            int sel;
            sel = $urandom_range(2);
            c = (sel == 0) ? MUL : (sel == 1) ? DIV : REM;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(9) - 4;
                3: a = $urandom_range(300);
                default: ;
            endcase
            run_op("rand", c, a, b, $urandom_range(1) == 1);
        end

        @(negedge clk);
        start_i = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
Multi-cycle multiply/divide unit in the EX stage of the RV32IM five-stage pipeline. It consumes the 5-bit ALU control code from the ALU decoder and handles MUL (01000), DIV (01001) and REM (01010); all other codes stay in the single-cycle ALU. It stalls the front of the pipeline while it iterates, then presents a one-cycle result for the EX/MEM register to capture.

Parameters:
XLEN, 32, operand/result width; only 32 is verified.
ITER, 32, iterations for shift-add MUL and restoring DIV/REM; must equal XLEN.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start_i  input  1  EX-stage instruction valid and not bubbled
alu_ctrl  input  5  ALU control code from the ALU decoder
op_a  input  XLEN  rs1 operand (multiplicand or dividend), forwarded value
op_b  input  XLEN  rs2 operand (multiplier or divisor), forwarded value
flush_i  input  1  pipeline flush (branch or jump redirect) for the EX instruction
stall_o  output  1  to hazard unit: freeze PC, IF/ID and ID/EX
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  XLEN  MUL low word, DIV quotient, or REM remainder

Behaviour:
- Single clock domain, clk; synchronous active-high reset rst.
- Reset: state=IDLE, busy_o=0, done_o=0, stall_o=0, result_o=0, counter=0, internal accumulators 0. Reset in any state, including mid-iteration, aborts the operation with no done_o.
- Accept: in IDLE with start_i=1, flush_i=0 and alu_ctrl in {01000, 01001, 01010}, the unit latches operands and the op at the edge ending cycle T.
  - Any other code, or start_i in BUSY or DONE, is ignored.
- States:
  - IDLE: on accept, go to DONE for special cases, otherwise to BUSY with counter=ITER-1.
  - BUSY: one iteration per cycle. When counter==0, go to DONE; otherwise decrement the counter.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Latency: a normal op is accepted in cycle T, iterates in T+1..T+32, and has done_o=1 in T+33. Special cases have done_o=1 in T+1.
- stall_o is combinational: (IDLE & start_i & MDU code & ~flush_i) | (state==BUSY). stall_o=0 in DONE, so the pipeline advances that cycle and the EX/MEM register captures result_o.
- result_o is registered. It is updated only when entering DONE and holds until the next accept.
- MUL: shift-add on the 32-bit operands; result is the low 32 bits of the product (sign-agnostic).
- DIV/REM are signed:
  - Unsigned restoring division on |op_a| and |op_b|.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved in IDLE with no iteration:
  - divisor==0: DIV gives 0xFFFFFFFF; REM gives op_a.
  - op_a==0x80000000 and op_b==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Flush:
  - flush_i in BUSY or DONE: go to IDLE next cycle; done_o is forced 0 in that cycle; result_o keeps its previous value.
  - flush_i in IDLE blocks the accept.
  - flush_i has priority over start_i and over counter completion.
- Back-to-back: the next instruction can be accepted in the first IDLE cycle after DONE, which is T+34 for a normal op.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MUL uses a single-cycle XLEN x XLEN multiply. IDLE goes straight to DONE, so done_o is in T+1 and stall_o is high only in cycle T. DIV/REM are unchanged.
- Undefined: MUL uses the 32-iteration shift-add path with done_o in T+33; no hardware multiplier is inferred.

Test Plan:
1. Reset, then MUL op_a=7, op_b=0xFFFFFFFD in cycle T -> stall_o high T..T+32, done_o in T+33 (T+1 with MDU_FAST_MUL_EN), result_o=0xFFFFFFEB.
2. DIV op_a=0xFFFFFFEC (-20), op_b=3 -> result_o=0xFFFFFFFA in T+33; REM on the same operands -> 0xFFFFFFFE; REM 20 by -3 -> 0x00000002.
3. DIV 100 by 0 -> done_o in T+1, result_o=0xFFFFFFFF; REM 100 by 0 -> result_o=100; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
4. Start DIV, assert flush_i in T+10 -> state IDLE in T+11, no done_o pulse, result_o unchanged; new MUL accepted in T+11 completes normally.
5. start_i with alu_ctrl=00000, and separately with 00111 -> stall_o=0, busy_o=0, no done_o; assert rst in T+5 of a DIV -> all outputs 0 next cycle.
6. Back-to-back MUL 3 by 5 then DIV 15 by 5 -> results 15 then 3; start_i held high during DONE is not accepted twice.
